// File: rtl/tbus_arbiter_pkg.sv
// Shared definitions for the tbus arbiter: operation encodings, FSM states and
// a helper for index widths.
package tbus_arbiter_pkg;

  localparam int unsigned TBUS_OP_W = 2;

  localparam logic [TBUS_OP_W-1:0] TBUS_READ  = 2'b00;
  localparam logic [TBUS_OP_W-1:0] TBUS_WRITE = 2'b01;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tbus_arb_sel.sv
// Winner selection: first requester found searching upward (with wrap) from ptr.
// A pointer tied to zero gives plain lowest-index-wins priority.
module tbus_arb_sel
  import tbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned PtrW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      for (int j = 0; j < int'(NUM_REQ); j++) begin
        if (!found && req[j] && (j == (int'(ptr) + i) % int'(NUM_REQ))) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tbus_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single tbus. Defining TBUS_ARB_RR_EN
// selects round-robin arbitration; otherwise fixed priority (index 0 highest).
module tbus_arbiter
  import tbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*XLEN-1:0]        req_index,
  input  logic [NUM_REQ*XLEN-1:0]        req_write_data,
  input  logic [NUM_REQ*XLEN-1:0]        req_write_mask,
  input  logic [NUM_REQ*TBUS_OP_W-1:0]   req_optype,
  input  logic [NUM_REQ-1:0]             req_flush,
  output logic [NUM_REQ-1:0]             resp_done,
  output logic [XLEN-1:0]                resp_read_data,
  output logic                           tbus_index_valid,
  input  logic                           tbus_index_ready,
  output logic [XLEN-1:0]                tbus_index,
  output logic [XLEN-1:0]                tbus_write_data,
  output logic [XLEN-1:0]                tbus_write_mask,
  output logic [TBUS_OP_W-1:0]           tbus_operation_type,
  input  logic [XLEN-1:0]                tbus_read_data,
  input  logic                           tbus_operation_done,
  output logic                           arb_busy
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     win_idx, sel_idx, ptr;
  logic [NUM_REQ-1:0]  eligible, win_oh;
  logic                accept;

  // A flushing requester never competes in the cycle it flushes.
  assign eligible = req_valid & ~req_flush;

  tbus_arb_sel #(
    .NUM_REQ (NUM_REQ)
  ) u_sel (
    .req (eligible),
    .ptr (ptr),
    .gnt (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_oh[i]) win_idx = IdxW'(i);
    end
  end

`ifdef TBUS_ARB_RR_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (sel_idx == IdxW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    sel_idx             = grant_q;
    accept              = 1'b0;
    req_ready           = '0;
    resp_done           = '0;
    resp_read_data      = '0;
    tbus_index_valid    = 1'b0;
    tbus_index          = '0;
    tbus_write_data     = '0;
    tbus_write_mask     = '0;
    tbus_operation_type = '0;

    case (state_q)
      StIdle: begin
        if (|eligible) begin
          sel_idx          = win_idx;
          grant_d          = win_idx;
          tbus_index_valid = 1'b1;
          state_d          = tbus_index_ready ? StWait : StReq;
        end
      end
      StReq: begin
        if (req_flush[grant_q] || !req_valid[grant_q]) begin
          state_d = StIdle;
        end else begin
          tbus_index_valid = 1'b1;
          if (tbus_index_ready) state_d = StWait;
        end
      end
      StWait: begin
        resp_read_data = tbus_read_data;
        if (req_flush[grant_q]) begin
          state_d = tbus_operation_done ? StIdle : StDrain;
        end else if (tbus_operation_done) begin
          resp_done[grant_q] = 1'b1;
          state_d            = StIdle;
        end
      end
      StDrain: begin
        if (tbus_operation_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (tbus_index_valid) begin
      tbus_index          = req_index[sel_idx*XLEN +: XLEN];
      tbus_write_data     = req_write_data[sel_idx*XLEN +: XLEN];
      tbus_write_mask     = req_write_mask[sel_idx*XLEN +: XLEN];
      tbus_operation_type = req_optype[sel_idx*TBUS_OP_W +: TBUS_OP_W];
      accept              = tbus_index_ready;
      req_ready[sel_idx]  = tbus_index_ready;
    end

    // Reset is synchronous, so outputs are masked explicitly while it is held.
    if (reset) begin
      accept              = 1'b0;
      req_ready           = '0;
      resp_done           = '0;
      resp_read_data      = '0;
      tbus_index_valid    = 1'b0;
      tbus_index          = '0;
      tbus_write_data     = '0;
      tbus_write_mask     = '0;
      tbus_operation_type = '0;
    end
  end

  assign arb_busy = (state_q != StIdle) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: directed vector table, multi-cycle
// sequences and randomized traffic against a transaction-level model.
module tb_tbus_arbiter;

  localparam int N = 2;
  localparam int X = 64;
  localparam logic [63:0] A0 = 64'h0000_0000_8000_0010;
  localparam logic [63:0] A1 = 64'h0000_0000_8000_0020;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid, req_ready, req_flush, resp_done;
  logic [N*X-1:0]   req_index, req_write_data, req_write_mask;
  logic [N*2-1:0]   req_optype;
  logic [X-1:0]     resp_read_data;
  logic             tbus_index_valid, tbus_index_ready;
  logic [X-1:0]     tbus_index, tbus_write_data, tbus_write_mask;
  logic [1:0]       tbus_operation_type;
  logic [X-1:0]     tbus_read_data;
  logic             tbus_operation_done, arb_busy;

  tbus_arbiter #(
    .NUM_REQ (N),
    .XLEN    (X)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_index           (req_index),
    .req_write_data      (req_write_data),
    .req_write_mask      (req_write_mask),
    .req_optype          (req_optype),
    .req_flush           (req_flush),
    .resp_done           (resp_done),
    .resp_read_data      (resp_read_data),
    .tbus_index_valid    (tbus_index_valid),
    .tbus_index_ready    (tbus_index_ready),
    .tbus_index          (tbus_index),
    .tbus_write_data     (tbus_write_data),
    .tbus_write_mask     (tbus_write_mask),
    .tbus_operation_type (tbus_operation_type),
    .tbus_read_data      (tbus_read_data),
    .tbus_operation_done (tbus_operation_done),
    .arb_busy            (arb_busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic rst, input logic [1:0] v, input logic [1:0] fl,
                        input logic rdy, input logic dn, input logic [63:0] rd);
    reset               = rst;
    req_valid           = v;
    req_flush           = fl;
    tbus_index_ready    = rdy;
    tbus_operation_done = dn;
    tbus_read_data      = rd;
    req_index           = {A1, A0};
    req_write_data      = '0;
    req_write_mask      = '0;
    req_optype          = '0;
  endtask

  // One cycle of directed stimulus with its expected outputs.
  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  fl;
    logic        rdy;
    logic        dn;
    logic [63:0] rd;
    logic        ev;
    logic [1:0]  erdy;
    logic [1:0]  edn;
    logic        eb;
    logic [63:0] eidx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [1:0] v, logic [1:0] fl, logic rdy, logic dn,
                              logic [63:0] rd, logic ev, logic [1:0] erdy, logic [1:0] edn,
                              logic eb, logic [63:0] eidx);
    vec_t r;
    r.rst = rst; r.v = v; r.fl = fl; r.rdy = rdy; r.dn = dn; r.rd = rd;
    r.ev = ev; r.erdy = erdy; r.edn = edn; r.eb = eb; r.eidx = eidx;
    return r;
  endfunction

  // Transaction-level reference: owner of the bus, whether its address was
  // accepted, and whether it was flushed while the operation was outstanding.
  int          m_owner, m_ptr, n_owner, n_ptr;
  bit          m_launched, m_aborted, n_launched, n_aborted;
  bit          e_valid, e_busy, e_rd_chk;
  logic [1:0]  e_ready, e_done;
  int          e_sel;

  task automatic model_eval();
    logic [1:0] elig;
    int w, c;
    e_valid = 0; e_ready = '0; e_done = '0; e_sel = 0; e_rd_chk = 0;
    e_busy = (m_owner >= 0);
    n_owner = m_owner; n_launched = m_launched; n_aborted = m_aborted; n_ptr = m_ptr;
    if (reset) begin
      e_busy = 0; n_owner = -1; n_launched = 0; n_aborted = 0; n_ptr = 0;
      return;
    end
    if (m_owner < 0) begin
      elig = req_valid & ~req_flush;
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && elig[c]) w = c;
      end
      if (w >= 0) begin
        e_valid = 1; e_sel = w; n_owner = w; n_launched = tbus_index_ready; n_aborted = 0;
      end
    end else if (!m_launched) begin
      if (!req_flush[m_owner] && req_valid[m_owner]) begin
        e_valid = 1; e_sel = m_owner; n_launched = tbus_index_ready;
      end else begin
        n_owner = -1;
      end
    end else if (!m_aborted) begin
      e_rd_chk = 1;
      if (req_flush[m_owner]) begin
        if (tbus_operation_done) n_owner = -1;
        else n_aborted = 1;
      end else if (tbus_operation_done) begin
        e_done[m_owner] = 1'b1;
        n_owner = -1;
      end
    end else if (tbus_operation_done) begin
      n_owner = -1;
    end
    if (e_valid && tbus_index_ready) begin
      e_ready[e_sel] = 1'b1;
`ifdef TBUS_ARB_RR_EN
      n_ptr = (e_sel + 1) % N;
`endif
    end
  endtask

  task automatic model_commit();
    m_owner    = n_owner;
    m_launched = (n_owner >= 0) ? n_launched : 0;
    m_aborted  = (n_owner >= 0) ? n_aborted : 0;
    m_ptr      = n_ptr;
  endtask

  initial begin
    int got;
    logic [63:0] exp_ord;
    logic [63:0] a0, a1, d0, d1, k0, k1;
    logic [1:0]  o0, o1;

    set_in(1, 2'b00, 2'b00, 0, 0, '0);
    tick();

    // Directed single-cycle vectors.
    tbl.push_back(mk(1, 2'b11, 2'b00, 1, 1, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 64'h0, 1, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 64'h0, 1, 2'b00, 2'b00, 1, A0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 64'h0, 1, 2'b00, 2'b00, 1, A0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 1, 0, 64'h0, 1, 2'b01, 2'b00, 1, A0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 64'h1234, 0, 2'b00, 2'b01, 1, 64'h0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1, 0, 64'h0, 1, 2'b01, 2'b00, 0, A0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 1, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 64'hDEAD_BEEF, 0, 2'b00, 2'b01, 1, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 1, 0, 64'h0, 1, 2'b10, 2'b00, 0, A1));
    tbl.push_back(mk(0, 2'b10, 2'b10, 0, 1, 64'h77, 0, 2'b00, 2'b00, 1, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 64'h0, 1, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1, 0, 64'h0, 0, 2'b00, 2'b00, 1, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 64'h0, 1, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(0, 2'b10, 2'b10, 1, 0, 64'h0, 0, 2'b00, 2'b00, 1, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 64'h0, 1, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(0, 2'b10, 2'b01, 1, 0, 64'h0, 1, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(0, 2'b00, 2'b01, 0, 1, 64'h5, 0, 2'b00, 2'b10, 1, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1, 0, 64'h0, 0, 2'b00, 2'b00, 0, 64'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 64'h9, 0, 2'b00, 2'b00, 0, 64'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].v, tbl[i].fl, tbl[i].rdy, tbl[i].dn, tbl[i].rd);
      #2;
      check($sformatf("vec%0d_valid", i), tbus_index_valid, tbl[i].ev);
      check($sformatf("vec%0d_ready", i), req_ready, tbl[i].erdy);
      check($sformatf("vec%0d_done", i), resp_done, tbl[i].edn);
      check($sformatf("vec%0d_busy", i), arb_busy, tbl[i].eb);
      if (tbl[i].ev) check($sformatf("vec%0d_index", i), tbus_index, tbl[i].eidx);
      if (tbl[i].edn != 2'b00) check($sformatf("vec%0d_rdata", i), resp_read_data, tbl[i].rd);
      tick();
    end

    // Grant order over four back-to-back transactions with both requesters valid.
    set_in(1, 2'b00, 2'b00, 0, 0, '0);
    tick();
    for (int t = 0; t < 4; t++) begin
      got = -1;
      for (int c = 0; c < 8 && got < 0; c++) begin
        set_in(0, 2'b11, 2'b00, 1, 0, '0);
        #2;
        if (req_ready == 2'b01) got = 0;
        else if (req_ready == 2'b10) got = 1;
        tick();
      end
`ifdef TBUS_ARB_RR_EN
      exp_ord = 64'(t % 2);
`else
      exp_ord = 64'd0;
`endif
      check($sformatf("order%0d", t), 64'(got), exp_ord);
      set_in(0, 2'b11, 2'b00, 1, 1, 64'hA5);
      tick();
    end

    // Flush in WAIT, done two cycles later, then requester 1 is served.
    set_in(1, 2'b00, 2'b00, 0, 0, '0);
    tick();
    set_in(0, 2'b11, 2'b00, 1, 0, '0);
    #2; check("drain_accept", req_ready, 2'b01);
    tick();
    set_in(0, 2'b10, 2'b01, 1, 0, '0);
    #2; check("drain_flush_done", resp_done, 2'b00);
    check("drain_flush_valid", tbus_index_valid, 1'b0);
    tick();
    set_in(0, 2'b10, 2'b00, 1, 0, '0);
    #2; check("drain_hold_valid", tbus_index_valid, 1'b0);
    check("drain_hold_busy", arb_busy, 1'b1);
    tick();
    set_in(0, 2'b10, 2'b00, 1, 1, 64'hBAD);
    #2; check("drain_absorb", resp_done, 2'b00);
    tick();
    set_in(0, 2'b10, 2'b00, 1, 0, '0);
    #2; check("drain_next_ready", req_ready, 2'b10);
    check("drain_next_index", tbus_index, A1);
    tick();
    set_in(0, 2'b00, 2'b00, 0, 1, 64'h42);
    #2; check("drain_next_done", resp_done, 2'b10);
    tick();

    // Reset while WAIT, then a stray done, then a fresh request.
    set_in(1, 2'b00, 2'b00, 0, 0, '0);
    tick();
    set_in(0, 2'b01, 2'b00, 1, 0, '0);
    #2; check("rstw_accept", req_ready, 2'b01);
    tick();
    set_in(1, 2'b00, 2'b00, 0, 1, 64'hDEAD);
    #2; check("rstw_done", resp_done, 2'b00);
    check("rstw_busy", arb_busy, 1'b0);
    check("rstw_rdata", resp_read_data, 64'h0);
    tick();
    set_in(0, 2'b00, 2'b00, 0, 1, 64'hDEAD);
    #2; check("rstw_stray_done", resp_done, 2'b00);
    check("rstw_stray_busy", arb_busy, 1'b0);
    tick();
    set_in(0, 2'b10, 2'b00, 1, 0, '0);
    #2; check("rstw_new_ready", req_ready, 2'b10);
    check("rstw_new_index", tbus_index, A1);
    tick();
    set_in(0, 2'b00, 2'b00, 0, 1, 64'h66);
    #2; check("rstw_new_done", resp_done, 2'b10);
    tick();

    // Randomized traffic against the reference model.
    m_owner = -1; m_ptr = 0; m_launched = 0; m_aborted = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      a0 = {$urandom, $urandom}; a1 = {$urandom, $urandom};
      d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      k0 = {$urandom, $urandom}; k1 = {$urandom, $urandom};
      o0 = 2'($urandom_range(0, 1)); o1 = 2'($urandom_range(0, 1));
      reset               = (cyc == 0) || ($urandom_range(0, 63) == 0);
      req_valid           = 2'($urandom);
      req_flush           = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      tbus_index_ready    = ($urandom_range(0, 2) != 0);
      tbus_operation_done = ($urandom_range(0, 2) == 0);
      tbus_read_data      = {$urandom, $urandom};
      req_index           = {a1, a0};
      req_write_data      = {d1, d0};
      req_write_mask      = {k1, k0};
      req_optype          = {o1, o0};
      #2;
      model_eval();
      check("rnd_valid", tbus_index_valid, e_valid);
      check("rnd_ready", req_ready, e_ready);
      check("rnd_done", resp_done, e_done);
      check("rnd_busy", arb_busy, e_busy);
      if (e_valid) begin
        check("rnd_index", tbus_index, (e_sel == 0) ? a0 : a1);
        check("rnd_wdata", tbus_write_data, (e_sel == 0) ? d0 : d1);
        check("rnd_wmask", tbus_write_mask, (e_sel == 0) ? k0 : k1);
        check("rnd_optype", tbus_operation_type, (e_sel == 0) ? o0 : o1);
      end
      if (e_rd_chk) check("rnd_rdata", resp_read_data, tbus_read_data);
      if (reset) begin
        check("rnd_rst_index", tbus_index, 64'h0);
        check("rnd_rst_rdata", resp_read_data, 64'h0);
      end
      model_commit();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
